// File: rtl/square_channel_core.sv
// Square-wave tone core: duty sequencer, length counter, volume envelope -> 4-bit sample.
// Latency: sample is registered from state one clock old; active follows its causes on the same edge.
// Backpressure: none; every tick pulse is consumed on the cycle it arrives. Macro: SQUARE_LENGTH_EN.
module square_channel_core #(
  parameter int LEN_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freq_tick,
  input  logic                len_tick,
  input  logic                env_tick,
  input  logic                trigger,
  input  logic [1:0]          duty,
  input  logic [LEN_BITS-1:0] len_load,
  input  logic                len_en,
  input  logic [3:0]          env_init,
  input  logic                env_dir,
  input  logic [2:0]          env_period,
  output logic [3:0]          sample,
  output logic                active
);

  logic [2:0] step;
  logic [3:0] volume;
  logic [2:0] env_cnt;
  logic       dir_lat;
  logic [2:0] per_lat;
  logic [7:0] pattern;
  logic       dac_off;
  logic       len_expire;

  // Channel is silenced while the envelope is configured as "zero and decreasing".
  assign dac_off = (env_init == 4'd0) && !env_dir;

  // Duty waveform, bit i is the level at sequencer step i.
  always_comb begin
    pattern = 8'b1000_0000;
    case (duty)
      2'b00:   pattern = 8'b1000_0000;
      2'b01:   pattern = 8'b1000_0001;
      2'b10:   pattern = 8'b1110_0001;
      default: pattern = 8'b0111_1110;
    endcase
  end

`ifdef SQUARE_LENGTH_EN
  localparam logic [LEN_BITS:0] LEN_FULL = {1'b1, {LEN_BITS{1'b0}}};
  localparam logic [LEN_BITS:0] LEN_ONE  = {{LEN_BITS{1'b0}}, 1'b1};

  logic [LEN_BITS:0] len_cnt;

  // Last length tick of a running note ends it; a trigger in the same cycle wins.
  assign len_expire = !trigger && len_tick && len_en && (len_cnt == LEN_ONE);

  // Length counter: loaded with the remaining tick count, stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_cnt <= '0;
    end else if (trigger) begin
      len_cnt <= LEN_FULL - {1'b0, len_load};
    end else if (len_tick && len_en && (len_cnt != '0)) begin
      len_cnt <= len_cnt - LEN_ONE;
    end
  end
`else
  logic unused_len;
  assign unused_len = ^{len_tick, len_en, len_load};
  assign len_expire = 1'b0;
`endif

  // Duty step advances on every period tick, sounding or not; never reset by trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      step <= 3'd0;
    end else if (freq_tick) begin
      step <= step + 3'd1;
    end
  end

  // Active flag: DAC-off overrides trigger, which overrides length expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
    end else if (dac_off) begin
      active <= 1'b0;
    end else if (trigger) begin
      active <= 1'b1;
    end else if (len_expire) begin
      active <= 1'b0;
    end
  end

  // Envelope: divide env ticks by the latched period, then step volume with saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      volume  <= 4'd0;
      env_cnt <= 3'd0;
      dir_lat <= 1'b0;
      per_lat <= 3'd0;
    end else if (trigger) begin
      volume  <= env_init;
      env_cnt <= env_period;
      dir_lat <= env_dir;
      per_lat <= env_period;
    end else if (env_tick && (per_lat != 3'd0)) begin
      if (env_cnt > 3'd1) begin
        env_cnt <= env_cnt - 3'd1;
      end else begin
        env_cnt <= per_lat;
        if (dir_lat && (volume != 4'd15)) begin
          volume <= volume + 4'd1;
        end else if (!dir_lat && (volume != 4'd0)) begin
          volume <= volume - 4'd1;
        end
      end
    end
  end

  // Output register: one clock behind state, cleared immediately by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= 4'd0;
    end else begin
      sample <= (active && pattern[step]) ? volume : 4'd0;
    end
  end

endmodule

// File: tb/tb_square_channel_core.sv
// Randomized and directed stimulus for square_channel_core with a queued scoreboard.
// Expected outputs come from a behavioural model built on the pattern strings and plain arithmetic.
// A monitor on the falling edge pops one expectation per clock and compares active and sample.
module tb_square_channel_core;
  localparam int LB = 6;

  logic          clk = 1'b0;
  logic          rst, freq_tick, len_tick, env_tick, trigger, len_en, env_dir;
  logic [1:0]    duty;
  logic [LB-1:0] len_load;
  logic [3:0]    env_init;
  logic [2:0]    env_period;
  logic [3:0]    sample;
  logic          active;

  always #5 clk = ~clk;

  square_channel_core #(.LEN_BITS(LB)) dut (
    .clk(clk), .rst(rst), .freq_tick(freq_tick), .len_tick(len_tick),
    .env_tick(env_tick), .trigger(trigger), .duty(duty), .len_load(len_load),
    .len_en(len_en), .env_init(env_init), .env_dir(env_dir),
    .env_period(env_period), .sample(sample), .active(active)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int q_act[$];
  int q_smp[$];
  string pats[4] = '{"00000001", "10000001", "10000111", "01111110"};

  // Reference state of the channel
  int m_active = 0, m_step = 0, m_vol = 0, m_rem = 0, m_ecnt = 0, m_dir = 0, m_per = 0;

  function automatic void check(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge
  task automatic model_edge();
    int exp_s;
    bit dac;
    if (rst) begin
      exp_s = 0;
      m_active = 0; m_step = 0; m_vol = 0; m_rem = 0; m_ecnt = 0; m_dir = 0; m_per = 0;
    end else begin
      exp_s = (m_active != 0 && pats[duty].getc(m_step) == "1") ? m_vol : 0;
      dac = (env_init == 4'd0) && !env_dir;
      if (freq_tick) m_step = (m_step + 1) % 8;
      if (trigger) begin
`ifdef SQUARE_LENGTH_EN
        m_rem = (1 << LB) - int'(len_load);
`endif
        m_vol = env_init; m_ecnt = env_period; m_dir = env_dir; m_per = env_period;
        m_active = 1;
      end else begin
`ifdef SQUARE_LENGTH_EN
        if (len_tick && len_en && m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) m_active = 0;
        end
`endif
        if (env_tick && m_per != 0) begin
          if (m_ecnt > 1) m_ecnt--;
          else begin
            m_ecnt = m_per;
            if (m_dir != 0) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
            else            m_vol = (m_vol > 0)  ? m_vol - 1 : 0;
          end
        end
      end
      if (dac) m_active = 0;
    end
    q_act.push_back(m_active);
    q_smp.push_back(exp_s);
  endtask

  // One clock: model sees the edge, pulses drop on the following falling edge
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    freq_tick = 1'b0; len_tick = 1'b0; env_tick = 1'b0; trigger = 1'b0;
  endtask

  task automatic pulses(int n, bit f, bit l, bit e);
    repeat (n) begin
      freq_tick = f; len_tick = l; env_tick = e;
      cyc();
    end
  endtask

  task automatic fire();
    trigger = 1'b1;
    cyc();
  endtask

  // Monitor: outputs are valid every cycle, compare against the oldest expectation
  always @(negedge clk) begin
    if (q_act.size() > 0) begin
      check("active", int'(active), q_act.pop_front());
      check("sample", int'(sample), q_smp.pop_front());
    end
  end

  initial begin
    rst = 1'b1; freq_tick = 1'b0; len_tick = 1'b0; env_tick = 1'b0; trigger = 1'b0;
    duty = 2'd0; len_load = '0; len_en = 1'b0; env_init = 4'd0; env_dir = 1'b0; env_period = 3'd0;
    @(negedge clk);
    repeat (2) cyc();
    rst = 1'b0;

    // Idle after reset: DAC off, nothing sounds
    pulses(20, 1, 0, 0);

    // 50 % duty at full volume, step through the sequence
    duty = 2'd2; env_init = 4'd15; env_period = 3'd0;
    fire();
    pulses(8, 1, 0, 0);
    pulses(2, 0, 0, 0);

    // Length expiry after 64-60 ticks, then the full 64-tick length
    duty = 2'd3; len_en = 1'b1; len_load = 6'd60;
    fire();
    pulses(1, 1, 0, 0);
    pulses(4, 0, 1, 0);
    pulses(3, 1, 0, 0);
    len_load = 6'd0;
    fire();
    pulses(63, 0, 1, 0);
    pulses(2, 1, 0, 0);
    pulses(1, 0, 1, 0);
    pulses(2, 1, 0, 0);

    // Decreasing envelope, period 3
    len_en = 1'b0; duty = 2'd3; env_init = 4'd2; env_dir = 1'b0; env_period = 3'd3;
    fire();
    pulses(1, 1, 0, 0);
    pulses(9, 0, 0, 1);
    pulses(2, 0, 0, 0);

    // Increasing envelope saturating at 15
    env_init = 4'd14; env_dir = 1'b1; env_period = 3'd1;
    fire();
    pulses(4, 0, 0, 1);
    pulses(2, 0, 0, 0);

    // Trigger coinciding with a length tick: tick is ignored
    len_en = 1'b1; len_load = 6'd60; env_init = 4'd9; env_dir = 1'b0; env_period = 3'd0;
    trigger = 1'b1; len_tick = 1'b1;
    cyc();
    pulses(3, 0, 1, 0);
    pulses(1, 1, 0, 0);
    pulses(1, 0, 1, 0);
    pulses(2, 0, 0, 0);

    // Trigger with DAC off leaves the channel silent
    env_init = 4'd0; env_dir = 1'b0;
    fire();
    pulses(3, 1, 0, 0);

    // Reset in the middle of a sounding note
    env_init = 4'd15; len_en = 1'b0; duty = 2'd3;
    fire();
    pulses(2, 1, 0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    pulses(2, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        duty       = 2'($urandom_range(0, 3));
        len_load   = LB'($urandom_range(0, (1 << LB) - 1));
        len_en     = ($urandom_range(0, 3) != 0);
        env_init   = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        env_dir    = ($urandom_range(0, 1) == 1);
        env_period = 3'($urandom_range(0, 7));
      end
      rst       = ($urandom_range(0, 299) == 0);
      freq_tick = ($urandom_range(0, 2) == 0);
      len_tick  = ($urandom_range(0, 3) == 0);
      env_tick  = ($urandom_range(0, 3) == 0);
      trigger   = ($urandom_range(0, 39) == 0);
      cyc();
    end
    rst = 1'b0;

    pulses(2, 0, 0, 0);
    @(negedge clk);
    check("scoreboard_drained", q_act.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
